axi_lite_sram_slave: RTL and testbench

- AXI4-Lite responder (slave) sitting behind the data-bus decode matrix on the slave-0 port, address window 0x8xxx_xxxx.
- Backs the window with a word-addressed on-chip SRAM of DEPTH 32-bit words.
- Independent write and read FSMs give blocking-bus-compatible single-outstanding transactions per direction.
- Returns OKAY/SLVERR on the 3-bit BRESP/RRESP fields used by the matrix.

---
 rtl/axi_lite_pkg.sv | 30 +++
 rtl/axi_lite_sram_array.sv | 52 +++++
 rtl/axi_lite_sram_slave.sv | 196 +++++++++++++++++++
 tb/tb_axi_lite_sram_slave.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the AXI4-Lite responders on the data-bus matrix:
//   - 3-bit response codes as carried on BRESP/RRESP by the matrix
//   - write/read FSM state encodings used by the SRAM responder
//   - window base addresses, also used by the decode matrix
// No ports (package).
// -----------------------------------------------------------------------------
package axi_lite_pkg;

  localparam logic [2:0] RESP_OKAY   = 3'b000;
  localparam logic [2:0] RESP_SLVERR = 3'b010;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_WAIT_AW = 2'd1,
    W_WAIT_W  = 2'd2,
    W_RESP    = 2'd3
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Slave-0 window: 0x8xxx_xxxx
  localparam logic [31:0] SLAVE0_BASE = 32'h8000_0000;
  localparam logic [31:0] SLAVE0_MASK = 32'hF000_0000;

endpackage

// File: rtl/axi_lite_sram_array.sv
// -----------------------------------------------------------------------------
// axi_lite_sram_array
// Word array with one synchronous write port (byte enables) and one
// synchronous read port with registered output. When both ports address the
// same word in the same cycle, the read returns the value held before the
// write. Contents are not reset.
// Ports:
//   clk_i    clock, rising edge
//   we_i     write enable
//   waddr_i  write word index
//   wdata_i  write data
//   wstrb_i  byte enables, bit i -> wdata_i[8i+7:8i]
//   re_i     read enable (captures mem[raddr_i] into rdata_o)
//   raddr_i  read word index
//   rdata_o  registered read data, held while re_i is low
// -----------------------------------------------------------------------------
module axi_lite_sram_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   wstrb_i,
  input  logic                  re_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Both ports update with non-blocking assignments on the same edge, so a
  // same-address read naturally observes the pre-write contents.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
    if (we_i) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_sram_slave
// AXI4-Lite responder on matrix slave-0 backed by a DEPTH-word SRAM.
// Independent write and read FSMs, one outstanding transaction per direction.
// Addresses outside [BASE, BASE + DEPTH*4) answer SLVERR; such writes are
// dropped and such reads return zero data. ADDR[1:0] is ignored.
// Ports:
//   Clk, Rst                     clock / synchronous active-low reset
//   AWVALID/AWADDR/AWPROT/AWREADY write address channel (AWPROT ignored)
//   WVALID/WDATA/WSTRB/WREADY     write data channel
//   BVALID/BRESP/BREADY           write response channel
//   ARVALID/ARADDR/ARPROT/ARREADY read address channel (ARPROT ignored)
//   RVALID/RDATA/RRESP/RREADY     read data channel
// -----------------------------------------------------------------------------
module axi_lite_sram_slave
  import axi_lite_pkg::*;
#(
  parameter int                ADDR_W = 32,
  parameter int                DATA_W = 32,
  parameter int                DEPTH  = 1024,
  parameter logic [ADDR_W-1:0] BASE   = SLAVE0_BASE
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                AWVALID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [2:0]          AWPROT,
  output logic                AWREADY,
  input  logic                WVALID,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  output logic                WREADY,
  output logic                BVALID,
  output logic [2:0]          BRESP,
  input  logic                BREADY,
  input  logic                ARVALID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [2:0]          ARPROT,
  output logic                ARREADY,
  output logic                RVALID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [2:0]          RRESP,
  input  logic                RREADY
);

  localparam int                IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH * 4);

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE;
    return off < SPAN;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE;
    return IDX_W'(off >> 2);
  endfunction

  wr_state_e           w_st_q, w_st_d;
  rd_state_e           r_st_q, r_st_d;
  logic                alive_q;
  logic                commit_q;
  logic                r_inr_q;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                lat_aw, lat_w;
  logic                aw_hs, w_hs, ar_hs;
  logic                arr_we;
  logic [DATA_W-1:0]   arr_rdata;
  logic                unused_prot;

  assign unused_prot = ^{AWPROT, ARPROT};

  // alive_q keeps every ready low while reset is held and for the reset
  // cycle itself; the FSM states alone would already read as IDLE then.
  assign AWREADY = alive_q && ((w_st_q == W_IDLE) || (w_st_q == W_WAIT_AW));
  assign WREADY  = alive_q && ((w_st_q == W_IDLE) || (w_st_q == W_WAIT_W));
  assign ARREADY = alive_q && (r_st_q == R_IDLE);

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID  && WREADY;
  assign ar_hs = ARVALID && ARREADY;

  // awaddr_q is frozen for the whole of W_RESP, so the response code
  // derived from it is stable until the B handshake.
  assign BVALID = (w_st_q == W_RESP);
  assign BRESP  = (BVALID && !in_range(awaddr_q)) ? RESP_SLVERR : RESP_OKAY;

  assign RVALID = (r_st_q == R_DATA);
  assign RRESP  = (RVALID && !r_inr_q) ? RESP_SLVERR : RESP_OKAY;
  assign RDATA  = (RVALID && r_inr_q) ? arr_rdata : '0;

  // Write FSM next state and capture enables
  always_comb begin
    w_st_d = w_st_q;
    lat_aw = 1'b0;
    lat_w  = 1'b0;
    case (w_st_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          lat_aw = 1'b1;
          lat_w  = 1'b1;
          w_st_d = W_RESP;
        end else if (aw_hs) begin
          lat_aw = 1'b1;
          w_st_d = W_WAIT_W;
        end else if (w_hs) begin
          lat_w  = 1'b1;
          w_st_d = W_WAIT_AW;
        end
      end
      W_WAIT_W: begin
        if (w_hs) begin
          lat_w  = 1'b1;
          w_st_d = W_RESP;
        end
      end
      W_WAIT_AW: begin
        if (aw_hs) begin
          lat_aw = 1'b1;
          w_st_d = W_RESP;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          w_st_d = W_IDLE;
        end
      end
      default: w_st_d = W_IDLE;
    endcase
  end

  // Read FSM next state
  always_comb begin
    r_st_d = r_st_q;
    case (r_st_q)
      R_IDLE:  if (ar_hs)  r_st_d = R_DATA;
      R_DATA:  if (RREADY) r_st_d = R_IDLE;
      default: r_st_d = R_IDLE;
    endcase
  end

  // Control state
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      w_st_q   <= W_IDLE;
      r_st_q   <= R_IDLE;
      alive_q  <= 1'b0;
      commit_q <= 1'b0;
      r_inr_q  <= 1'b0;
    end else begin
      alive_q  <= 1'b1;
      w_st_q   <= w_st_d;
      r_st_q   <= r_st_d;
      // One-cycle pulse on entry to W_RESP: the array write lands at the
      // end of that first response cycle.
      commit_q <= (w_st_q != W_RESP) && (w_st_d == W_RESP);
      if (ar_hs) begin
        r_inr_q <= in_range(ARADDR);
      end
    end
  end

  // Captured write request
  always_ff @(posedge Clk) begin
    if (lat_aw) begin
      awaddr_q <= AWADDR;
    end
    if (lat_w) begin
      wdata_q <= WDATA;
      wstrb_q <= WSTRB;
    end
  end

  // Rst gates the commit so a reset landing on the commit edge drops it.
  assign arr_we = commit_q && in_range(awaddr_q) && Rst;

  axi_lite_sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk_i   (Clk),
    .we_i    (arr_we),
    .waddr_i (word_idx(awaddr_q)),
    .wdata_i (wdata_q),
    .wstrb_i (wstrb_q),
    .re_i    (ar_hs),
    .raddr_i (word_idx(ARADDR)),
    .rdata_o (arr_rdata)
  );

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
module tb_axi_lite_sram_slave;

  localparam logic [31:0] WBASE = 32'h8000_0000;
  localparam int          NW    = 1024;

  logic        Clk;
  logic        Rst;
  logic        AWVALID;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        AWREADY;
  logic        WVALID;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WREADY;
  logic        BVALID;
  logic [2:0]  BRESP;
  logic        BREADY;
  logic        ARVALID;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        ARREADY;
  logic        RVALID;
  logic [31:0] RDATA;
  logic [2:0]  RRESP;
  logic        RREADY;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m [NW];

  axi_lite_sram_slave dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .AWVALID (AWVALID),
    .AWADDR  (AWADDR),
    .AWPROT  (AWPROT),
    .AWREADY (AWREADY),
    .WVALID  (WVALID),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WREADY  (WREADY),
    .BVALID  (BVALID),
    .BRESP   (BRESP),
    .BREADY  (BREADY),
    .ARVALID (ARVALID),
    .ARADDR  (ARADDR),
    .ARPROT  (ARPROT),
    .ARREADY (ARREADY),
    .RVALID  (RVALID),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RREADY  (RREADY)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  function automatic logic in_win(input logic [31:0] a);
    return (a - WBASE) < 32'd4096;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - WBASE) >> 2);
  endfunction

  function automatic logic [2:0] exp_resp(input logic [31:0] a);
    return in_win(a) ? 3'b000 : 3'b010;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    return in_win(a) ? mem_m[widx(a)] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_win(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mem_m[widx(a)][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  // ---------------- bus drivers ----------------
  // mode 0: AW+W together, 1: AW then W after gap cycles, 2: W then AW
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int mode, input int gap,
                          output logic [2:0] resp, output logic first);
    int n;
    BREADY = 1'b1;
    @(negedge Clk);
    n = 0;
    while (!(AWREADY && WREADY) && n < 100) begin @(negedge Clk); n++; end
    if (n >= 100) begin bad++; $display("FAIL write_idle_timeout got=busy exp=idle"); end
    AWADDR = a; WDATA = d; WSTRB = s; AWPROT = 3'($urandom_range(0, 7));
    case (mode)
      1: begin
        AWVALID = 1'b1; @(posedge Clk); #1; AWVALID = 1'b0;
        repeat (gap) begin @(posedge Clk); #1; end
        WVALID = 1'b1; @(posedge Clk); #1; WVALID = 1'b0;
      end
      2: begin
        WVALID = 1'b1; @(posedge Clk); #1; WVALID = 1'b0;
        repeat (gap) begin @(posedge Clk); #1; end
        AWVALID = 1'b1; @(posedge Clk); #1; AWVALID = 1'b0;
      end
      default: begin
        AWVALID = 1'b1; WVALID = 1'b1; @(posedge Clk); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
      end
    endcase
    @(negedge Clk);
    first = BVALID;
    n = 0;
    while (!BVALID && n < 100) begin @(negedge Clk); n++; end
    if (n >= 100) begin bad++; $display("FAIL bvalid_timeout got=0 exp=1"); end
    resp = BRESP;
    @(posedge Clk); #1;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                         output logic [2:0] resp, output logic first);
    int n;
    RREADY = 1'b1;
    @(negedge Clk);
    n = 0;
    while (!ARREADY && n < 100) begin @(negedge Clk); n++; end
    if (n >= 100) begin bad++; $display("FAIL read_idle_timeout got=busy exp=idle"); end
    ARADDR = a; ARPROT = 3'($urandom_range(0, 7)); ARVALID = 1'b1;
    @(posedge Clk); #1; ARVALID = 1'b0;
    @(negedge Clk);
    first = RVALID;
    n = 0;
    while (!RVALID && n < 100) begin @(negedge Clk); n++; end
    if (n >= 100) begin bad++; $display("FAIL rvalid_timeout got=0 exp=1"); end
    data = RDATA;
    resp = RRESP;
    @(posedge Clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    Rst = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    total++; if (AWREADY !== 1'b0) begin bad++; $display("FAIL rst_awready got=%b exp=0", AWREADY); end
    total++; if (WREADY  !== 1'b0) begin bad++; $display("FAIL rst_wready got=%b exp=0", WREADY); end
    total++; if (ARREADY !== 1'b0) begin bad++; $display("FAIL rst_arready got=%b exp=0", ARREADY); end
    total++; if (BVALID  !== 1'b0) begin bad++; $display("FAIL rst_bvalid got=%b exp=0", BVALID); end
    total++; if (RVALID  !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", RVALID); end
    total++; if ({BRESP, RRESP, RDATA} !== 38'h0) begin
      bad++; $display("FAIL rst_resp_data got=%h/%h/%h exp=0", BRESP, RRESP, RDATA);
    end
    Rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    total++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      bad++; $display("FAIL post_rst_ready got=%b exp=111", {AWREADY, WREADY, ARREADY});
    end
  endtask

  task automatic init_mem;
    logic [2:0] r; logic f; logic [31:0] v;
    for (int i = 0; i < NW; i++) begin
      v = $urandom;
      do_write(WBASE + 32'(i * 4), v, 4'hF, 0, 0, r, f);
      model_write(WBASE + 32'(i * 4), v, 4'hF);
    end
  endtask

  task automatic test_aligned;
    logic [2:0] r; logic f; logic [31:0] d;
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, r, f);
    model_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    total++; if (f !== 1'b1)    begin bad++; $display("FAIL aligned_b_latency got=%b exp=1", f); end
    total++; if (r !== 3'b000)  begin bad++; $display("FAIL aligned_bresp got=%b exp=000", r); end
    do_read(32'h8000_0010, d, r, f);
    total++; if (f !== 1'b1)    begin bad++; $display("FAIL aligned_r_latency got=%b exp=1", f); end
    total++; if (d !== exp_rdata(32'h8000_0010)) begin
      bad++; $display("FAIL aligned_rdata got=%h exp=%h", d, exp_rdata(32'h8000_0010));
    end
    total++; if (r !== 3'b000)  begin bad++; $display("FAIL aligned_rresp got=%b exp=000", r); end
  endtask

  task automatic test_w_first;
    logic [2:0] r; logic f; logic [31:0] d;
    do_write(32'h8000_0020, 32'h1122_3344, 4'hF, 0, 0, r, f);
    model_write(32'h8000_0020, 32'h1122_3344, 4'hF);
    do_write(32'h8000_0020, 32'hAABB_CCDD, 4'h5, 2, 2, r, f);
    model_write(32'h8000_0020, 32'hAABB_CCDD, 4'h5);
    total++; if (f !== 1'b1)   begin bad++; $display("FAIL wfirst_b_latency got=%b exp=1", f); end
    total++; if (r !== 3'b000) begin bad++; $display("FAIL wfirst_bresp got=%b exp=000", r); end
    do_read(32'h8000_0020, d, r, f);
    total++; if (d !== exp_rdata(32'h8000_0020)) begin
      bad++; $display("FAIL wfirst_merge got=%h exp=%h", d, exp_rdata(32'h8000_0020));
    end
    // zero strobe leaves the word alone but still answers OKAY
    do_write(32'h8000_0020, 32'h0, 4'h0, 1, 1, r, f);
    total++; if (r !== 3'b000) begin bad++; $display("FAIL zstrb_bresp got=%b exp=000", r); end
    do_read(32'h8000_0020, d, r, f);
    total++; if (d !== exp_rdata(32'h8000_0020)) begin
      bad++; $display("FAIL zstrb_data got=%h exp=%h", d, exp_rdata(32'h8000_0020));
    end
  endtask

  task automatic test_out_of_range;
    logic [2:0] r; logic f; logic [31:0] d;
    do_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0, 0, r, f);
    model_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF);
    do_write(32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, 0, r, f);
    total++; if (r !== exp_resp(32'h8000_1000)) begin
      bad++; $display("FAIL oor_bresp got=%b exp=%b", r, exp_resp(32'h8000_1000));
    end
    do_read(32'h8000_1000, d, r, f);
    total++; if (r !== exp_resp(32'h8000_1000)) begin
      bad++; $display("FAIL oor_rresp got=%b exp=%b", r, exp_resp(32'h8000_1000));
    end
    total++; if (d !== 32'h0) begin bad++; $display("FAIL oor_rdata got=%h exp=0", d); end
    do_read(32'h8000_0000, d, r, f);
    total++; if (d !== exp_rdata(32'h8000_0000)) begin
      bad++; $display("FAIL oor_alias_untouched got=%h exp=%h", d, exp_rdata(32'h8000_0000));
    end
    do_read(32'h7FFF_FFFC, d, r, f);
    total++; if (r !== exp_resp(32'h7FFF_FFFC)) begin
      bad++; $display("FAIL below_base_rresp got=%b exp=%b", r, exp_resp(32'h7FFF_FFFC));
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_d;
    BREADY = 1'b0;
    @(negedge Clk);
    AWADDR = 32'h8000_2000; WDATA = 32'h1234_5678; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    @(posedge Clk); #1; AWVALID = 1'b0; WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      total++; if ({BVALID, BRESP} !== {1'b1, exp_resp(32'h8000_2000)}) begin
        bad++; $display("FAIL bp_b_hold[%0d] got=%b/%b exp=1/%b", i, BVALID, BRESP, exp_resp(32'h8000_2000));
      end
      total++; if ({AWREADY, WREADY} !== 2'b00) begin
        bad++; $display("FAIL bp_w_ready[%0d] got=%b exp=00", i, {AWREADY, WREADY});
      end
    end
    BREADY = 1'b1;
    @(posedge Clk); #1;
    @(negedge Clk);
    total++; if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
      bad++; $display("FAIL bp_b_release got=%b exp=011", {BVALID, AWREADY, WREADY});
    end
    exp_d = exp_rdata(32'h8000_001C);
    RREADY = 1'b0;
    ARADDR = 32'h8000_001C; ARVALID = 1'b1;
    @(posedge Clk); #1; ARVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      total++; if ({RVALID, RRESP, RDATA} !== {1'b1, 3'b000, exp_d}) begin
        bad++; $display("FAIL bp_r_hold[%0d] got=%b/%b/%h exp=1/000/%h", i, RVALID, RRESP, RDATA, exp_d);
      end
      total++; if (ARREADY !== 1'b0) begin bad++; $display("FAIL bp_arready[%0d] got=%b exp=0", i, ARREADY); end
    end
    RREADY = 1'b1;
    @(posedge Clk); #1;
    @(negedge Clk);
    total++; if ({RVALID, ARREADY} !== 2'b01) begin
      bad++; $display("FAIL bp_r_release got=%b exp=01", {RVALID, ARREADY});
    end
  endtask

  task automatic test_collision;
    logic [2:0] r; logic f; logic [31:0] d, old;
    do_write(32'h8000_0040, 32'h0, 4'hF, 0, 0, r, f);
    model_write(32'h8000_0040, 32'h0, 4'hF);
    old = exp_rdata(32'h8000_0040);
    BREADY = 1'b1; RREADY = 1'b1;
    @(negedge Clk);
    AWADDR = 32'h8000_0040; WDATA = 32'h5A5A_5A5A; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1;
    @(posedge Clk); #1; AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 32'h8000_0040; ARVALID = 1'b1;
    @(posedge Clk); #1; ARVALID = 1'b0;
    @(negedge Clk);
    total++; if ({RVALID, RDATA} !== {1'b1, old}) begin
      bad++; $display("FAIL collide_old_data got=%b/%h exp=1/%h", RVALID, RDATA, old);
    end
    model_write(32'h8000_0040, 32'h5A5A_5A5A, 4'hF);
    @(posedge Clk); #1;
    do_read(32'h8000_0040, d, r, f);
    total++; if (d !== exp_rdata(32'h8000_0040)) begin
      bad++; $display("FAIL collide_new_data got=%h exp=%h", d, exp_rdata(32'h8000_0040));
    end
  endtask

  task automatic test_reset_mid;
    logic [2:0] r; logic f; logic [31:0] d;
    BREADY = 1'b1;
    @(negedge Clk);
    AWADDR = 32'h8000_0080; AWVALID = 1'b1;
    WDATA = 32'h0BAD_0BAD; WSTRB = 4'hF;
    @(posedge Clk); #1; AWVALID = 1'b0;
    @(negedge Clk);
    total++; if ({AWREADY, WREADY} !== 2'b01) begin
      bad++; $display("FAIL mid_wait_w got=%b exp=01", {AWREADY, WREADY});
    end
    Rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      total++; if ({BVALID, AWREADY, WREADY} !== 3'b000) begin
        bad++; $display("FAIL mid_rst_out[%0d] got=%b exp=000", i, {BVALID, AWREADY, WREADY});
      end
    end
    Rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    total++; if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
      bad++; $display("FAIL mid_rst_idle got=%b exp=011", {BVALID, AWREADY, WREADY});
    end
    do_read(32'h8000_0080, d, r, f);
    total++; if (d !== exp_rdata(32'h8000_0080)) begin
      bad++; $display("FAIL mid_rst_nowrite got=%h exp=%h", d, exp_rdata(32'h8000_0080));
    end
  endtask

  task automatic test_random;
    logic [2:0] r; logic f; logic [31:0] a, d, v; logic [3:0] s;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0)
        a = WBASE + 32'd4096 + 32'($urandom_range(0, 32'hFFFF));
      else
        a = WBASE + 32'($urandom_range(0, NW - 1) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom; s = 4'($urandom_range(0, 15));
        do_write(a, v, s, $urandom_range(0, 2), $urandom_range(0, 3), r, f);
        total++; if ({f, r} !== {1'b1, exp_resp(a)}) begin
          bad++; $display("FAIL rnd_write[%0d] a=%h got=%b/%b exp=1/%b", i, a, f, r, exp_resp(a));
        end
        model_write(a, v, s);
      end else begin
        do_read(a, d, r, f);
        total++; if ({f, r, d} !== {1'b1, exp_resp(a), exp_rdata(a)}) begin
          bad++; $display("FAIL rnd_read[%0d] a=%h got=%b/%b/%h exp=1/%b/%h",
                          i, a, f, r, d, exp_resp(a), exp_rdata(a));
        end
      end
    end
  endtask

  initial begin
    Rst = 1'b0; AWVALID = 1'b0; AWADDR = '0; AWPROT = '0;
    WVALID = 1'b0; WDATA = '0; WSTRB = '0; BREADY = 1'b0;
    ARVALID = 1'b0; ARADDR = '0; ARPROT = '0; RREADY = 1'b0;
    test_reset();
    init_mem();
    test_aligned();
    test_w_first();
    test_out_of_range();
    test_backpressure();
    test_collision();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
